// File: rtl/mem_stage_if.sv
// Data-memory bus between the MEM stage (master) and the data memory (slave).
// A request is held high until the one-cycle ready pulse; read data is valid
// only alongside ready.
interface mem_stage_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              DM_req_o;
    logic [3:0]        DM_web_o;
    logic [ADDR_W-1:0] DM_addr_o;
    logic [DATA_W-1:0] DM_wdata_o;
    logic [DATA_W-1:0] DM_rdata_i;
    logic              DM_ready_i;

    modport master (
        output DM_req_o, DM_web_o, DM_addr_o, DM_wdata_o,
        input  DM_rdata_i, DM_ready_i
    );

    modport slave (
        input  DM_req_o, DM_web_o, DM_addr_o, DM_wdata_o,
        output DM_rdata_i, DM_ready_i
    );
endinterface

// File: rtl/mem_stage.sv
// MEM pipeline stage plus MEM/WB register. Issues data-memory requests for
// loads/stores, builds byte enables and lane-replicated store data, stalls
// the pipeline while an access is outstanding, and parks returned load data
// in a hold buffer when the downstream pipeline is frozen on the ready cycle.
module mem_stage #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              MEM_stage_valid_i,
    input  logic [DATA_W-1:0] MEM_stage_ALU_result_i,
    input  logic [DATA_W-1:0] MEM_stage_rs2_data_i,
    input  logic [2:0]        MEM_stage_funct3_i,
    input  logic [4:0]        MEM_stage_rd_i,
    input  logic              MEM_stage_Cont_MemRead_i,
    input  logic              MEM_stage_Cont_MemWrite_i,
    input  logic              MEM_stage_Cont_RegWrite_i,
    input  logic              MEM_stage_Cont_MemtoReg_i,
    input  logic              MEM_stage_stall_i,
    mem_stage_if.master       dm,
    output logic              MEM_stage_stall_o,
    output logic [2:0]        WB_loadfunc_o,
    output logic [DATA_W-1:0] WB_DM_data_o,
    output logic [DATA_W-1:0] WB_ALU_result_o,
    output logic [4:0]        WB_rd_o,
    output logic              WB_Cont_RegWrite_o,
    output logic              WB_Cont_MemtoReg_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_HOLD = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] hold_q;
    logic [2:0]        wb_loadfunc_q;
    logic [DATA_W-1:0] wb_dm_data_q, wb_dm_data_d;
    logic [DATA_W-1:0] wb_alu_q;
    logic [4:0]        wb_rd_q;
    logic              wb_regwrite_q;
    logic              wb_memtoreg_q;

    logic              mem_op;
    logic              is_load;
    logic              req;
    logic              stall;
    logic              capture;
    logic              use_hold;
    logic              wb_en;
    logic [3:0]        web;
    logic [DATA_W-1:0] wdata;

    assign mem_op  = MEM_stage_valid_i & (MEM_stage_Cont_MemRead_i | MEM_stage_Cont_MemWrite_i);
    assign is_load = MEM_stage_valid_i & MEM_stage_Cont_MemRead_i;

    // State register; reset aborts any outstanding access.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and handshake outputs; IDLE issues the request in the same cycle.
    always_comb begin
        state_d  = state_q;
        req      = 1'b0;
        stall    = 1'b0;
        capture  = 1'b0;
        use_hold = 1'b0;
        case (state_q)
            S_IDLE: begin
                req   = mem_op;
                stall = mem_op & ~dm.DM_ready_i;
                if (mem_op) begin
                    if (dm.DM_ready_i) begin
                        capture = MEM_stage_stall_i;
                        state_d = MEM_stage_stall_i ? S_HOLD : S_IDLE;
                    end else begin
                        state_d = S_REQ;
                    end
                end
            end
            S_REQ: begin
                req   = 1'b1;
                stall = ~dm.DM_ready_i;
                if (dm.DM_ready_i) begin
                    capture = MEM_stage_stall_i;
                    state_d = MEM_stage_stall_i ? S_HOLD : S_IDLE;
                end
            end
            S_HOLD: begin
                use_hold = 1'b1;
                if (!MEM_stage_stall_i) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Byte enables and lane-replicated store data; loads drive no enables.
    always_comb begin
        web   = 4'b1111;
        wdata = MEM_stage_rs2_data_i;
        case (MEM_stage_funct3_i[1:0])
            2'b00: begin
                web   = 4'b0001 << MEM_stage_ALU_result_i[1:0];
                wdata = {4{MEM_stage_rs2_data_i[7:0]}};
            end
            2'b01: begin
                web   = MEM_stage_ALU_result_i[1] ? 4'b1100 : 4'b0011;
                wdata = {2{MEM_stage_rs2_data_i[15:0]}};
            end
            default: begin
                web   = 4'b1111;
                wdata = MEM_stage_rs2_data_i;
            end
        endcase
        if (!MEM_stage_Cont_MemWrite_i) begin
            web = 4'b0000;
        end
    end

    // Reset forces the request and stall low immediately, even mid-access.
    assign dm.DM_req_o        = req & rstn;
    assign MEM_stage_stall_o  = stall & rstn;
    assign dm.DM_web_o        = web;
    assign dm.DM_wdata_o      = wdata;
    assign dm.DM_addr_o       = {MEM_stage_ALU_result_i[ADDR_W-1:2], 2'b00};

    assign wb_en        = ~MEM_stage_stall_i & ~stall;
    assign wb_dm_data_d = is_load ? (use_hold ? hold_q : dm.DM_rdata_i) : '0;

    // Hold buffer keeps read data returned while the pipeline is frozen.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            hold_q <= '0;
        end else if (capture) begin
            hold_q <= dm.DM_rdata_i;
        end
    end

    // MEM/WB register; bubbles never write the register file.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wb_loadfunc_q <= '0;
            wb_dm_data_q  <= '0;
            wb_alu_q      <= '0;
            wb_rd_q       <= '0;
            wb_regwrite_q <= 1'b0;
            wb_memtoreg_q <= 1'b0;
        end else if (wb_en) begin
            wb_loadfunc_q <= MEM_stage_funct3_i;
            wb_dm_data_q  <= wb_dm_data_d;
            wb_alu_q      <= MEM_stage_ALU_result_i;
            wb_rd_q       <= MEM_stage_rd_i;
            wb_regwrite_q <= MEM_stage_Cont_RegWrite_i & MEM_stage_valid_i;
            wb_memtoreg_q <= MEM_stage_Cont_MemtoReg_i;
        end
    end

    assign WB_loadfunc_o      = wb_loadfunc_q;
    assign WB_DM_data_o       = wb_dm_data_q;
    assign WB_ALU_result_o    = wb_alu_q;
    assign WB_rd_o            = wb_rd_q;
    assign WB_Cont_RegWrite_o = wb_regwrite_q;
    assign WB_Cont_MemtoReg_o = wb_memtoreg_q;

endmodule

// File: tb/tb_mem_stage.sv
// Testbench for mem_stage: directed scenarios plus randomized transactions
// checked against a transaction-level reference model.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        valid, mr, mw, rw, m2r, stall_i;
    logic [31:0] alu, rs2;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic        stall_o;
    logic [2:0]  wb_lf;
    logic [31:0] wb_dm, wb_alu;
    logic [4:0]  wb_rd;
    logic        wb_rw, wb_m2r;

    int checks = 0;
    int failures = 0;

    mem_stage_if dmif ();

    mem_stage dut (
        .clk                      (clk),
        .rstn                     (rstn),
        .MEM_stage_valid_i        (valid),
        .MEM_stage_ALU_result_i   (alu),
        .MEM_stage_rs2_data_i     (rs2),
        .MEM_stage_funct3_i       (f3),
        .MEM_stage_rd_i           (rd),
        .MEM_stage_Cont_MemRead_i (mr),
        .MEM_stage_Cont_MemWrite_i(mw),
        .MEM_stage_Cont_RegWrite_i(rw),
        .MEM_stage_Cont_MemtoReg_i(m2r),
        .MEM_stage_stall_i        (stall_i),
        .dm                       (dmif),
        .MEM_stage_stall_o        (stall_o),
        .WB_loadfunc_o            (wb_lf),
        .WB_DM_data_o             (wb_dm),
        .WB_ALU_result_o          (wb_alu),
        .WB_rd_o                  (wb_rd),
        .WB_Cont_RegWrite_o       (wb_rw),
        .WB_Cont_MemtoReg_o       (wb_m2r)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic drive(input logic v, input logic r_, input logic w_, input logic regw,
                         input logic mtr, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] d, input logic [4:0] r);
        valid = v; mr = r_; mw = w_; rw = regw; m2r = mtr; f3 = f; alu = a; rs2 = d; rd = r;
    endtask

    task automatic test_reset();
        drive(1, 1, 0, 1, 1, 3'b010, 32'h40, 32'h0, 5'd1);
        stall_i = 0; dmif.DM_ready_i = 0; dmif.DM_rdata_i = 32'h0;
        rstn = 0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (dmif.DM_req_o !== 1'b0) begin failures++; $display("FAIL reset_req: got %b want 0", dmif.DM_req_o); end
        checks++; if (stall_o !== 1'b0) begin failures++; $display("FAIL reset_stall: got %b want 0", stall_o); end
        checks++; if ({wb_lf, wb_dm, wb_alu, wb_rd, wb_rw, wb_m2r} !== '0) begin failures++;
            $display("FAIL reset_wb: got lf=%h dm=%h alu=%h rd=%h rw=%b m2r=%b want all 0", wb_lf, wb_dm, wb_alu, wb_rd, wb_rw, wb_m2r); end
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 3'b000, 32'h0, 32'h0, 5'd0);
        rstn = 1;
    endtask

    task automatic test_sb();
        @(negedge clk);
        drive(1, 0, 1, 0, 0, 3'b000, 32'h0000_0103, 32'h1234_56A5, 5'd0);
        dmif.DM_ready_i = 1; dmif.DM_rdata_i = 32'h0;
        #1;
        checks++; if (dmif.DM_req_o !== 1'b1) begin failures++; $display("FAIL sb_req: got %b want 1", dmif.DM_req_o); end
        checks++; if (dmif.DM_web_o !== 4'b1000) begin failures++; $display("FAIL sb_web: got %b want 1000", dmif.DM_web_o); end
        checks++; if (dmif.DM_wdata_o !== 32'hA5A5_A5A5) begin failures++; $display("FAIL sb_wdata: got %h want a5a5a5a5", dmif.DM_wdata_o); end
        checks++; if (dmif.DM_addr_o !== 32'h100) begin failures++; $display("FAIL sb_addr: got %h want 100", dmif.DM_addr_o); end
        checks++; if (stall_o !== 1'b0) begin failures++; $display("FAIL sb_stall: got %b want 0", stall_o); end
        @(posedge clk); #1;
        checks++; if (wb_alu !== 32'h103 || wb_dm !== 32'h0 || wb_rw !== 1'b0) begin failures++;
            $display("FAIL sb_wb: got alu=%h dm=%h rw=%b want 103/0/0", wb_alu, wb_dm, wb_rw); end
    endtask

    task automatic test_lw_wait();
        int reqc = 0;
        int stc = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            drive(1, 1, 0, 1, 1, 3'b010, 32'h200, 32'h0, 5'd5);
            dmif.DM_ready_i = (c == 3);
            dmif.DM_rdata_i = (c == 3) ? 32'hDEAD_BEEF : 32'h0BAD_0BAD;
            #1;
            reqc += int'(dmif.DM_req_o);
            stc  += int'(stall_o);
            checks++; if (wb_alu !== 32'h103) begin failures++; $display("FAIL lw_wb_held: got alu=%h want 103", wb_alu); end
            @(posedge clk);
        end
        #1;
        checks++; if (reqc != 4) begin failures++; $display("FAIL lw_req_cycles: got %0d want 4", reqc); end
        checks++; if (stc != 3) begin failures++; $display("FAIL lw_stall_cycles: got %0d want 3", stc); end
        checks++; if (wb_dm !== 32'hDEAD_BEEF || wb_lf !== 3'b010 || wb_rd !== 5'd5 || wb_rw !== 1'b1 || wb_m2r !== 1'b1) begin failures++;
            $display("FAIL lw_wb: got dm=%h lf=%b rd=%0d rw=%b m2r=%b want deadbeef/010/5/1/1", wb_dm, wb_lf, wb_rd, wb_rw, wb_m2r); end
    endtask

    task automatic test_lh_hold();
        int reqc = 0;
        @(negedge clk);
        drive(1, 1, 0, 1, 1, 3'b001, 32'h202, 32'h0, 5'd9);
        dmif.DM_ready_i = 1; dmif.DM_rdata_i = 32'h0000_CAFE; stall_i = 1;
        #1;
        reqc += int'(dmif.DM_req_o);
        checks++; if (dmif.DM_web_o !== 4'b0000 || stall_o !== 1'b0) begin failures++;
            $display("FAIL lh_issue: got web=%b stall=%b want 0000/0", dmif.DM_web_o, stall_o); end
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            dmif.DM_ready_i = 0; dmif.DM_rdata_i = 32'hFFFF_FFFF; stall_i = (c == 0);
            #1;
            reqc += int'(dmif.DM_req_o);
            checks++; if (stall_o !== 1'b0 || wb_alu !== 32'h200) begin failures++;
                $display("FAIL lh_hold: got stall=%b alu=%h want 0/200", stall_o, wb_alu); end
        end
        @(posedge clk); #1;
        checks++; if (reqc != 1) begin failures++; $display("FAIL lh_single_req: got %0d want 1", reqc); end
        checks++; if (wb_dm !== 32'h0000_CAFE || wb_alu !== 32'h202 || wb_lf !== 3'b001) begin failures++;
            $display("FAIL lh_wb: got dm=%h alu=%h lf=%b want 0000cafe/202/001", wb_dm, wb_alu, wb_lf); end
    endtask

    task automatic test_alu();
        @(negedge clk);
        drive(1, 0, 0, 1, 0, 3'b000, 32'h55, 32'h0, 5'd7);
        dmif.DM_ready_i = 0; stall_i = 0;
        #1;
        checks++; if (dmif.DM_req_o !== 1'b0 || stall_o !== 1'b0) begin failures++;
            $display("FAIL alu_noreq: got req=%b stall=%b want 0/0", dmif.DM_req_o, stall_o); end
        @(posedge clk); #1;
        checks++; if (wb_alu !== 32'h55 || wb_dm !== 32'h0 || wb_rw !== 1'b1 || wb_rd !== 5'd7) begin failures++;
            $display("FAIL alu_wb: got alu=%h dm=%h rw=%b rd=%0d want 55/0/1/7", wb_alu, wb_dm, wb_rw, wb_rd); end
        @(negedge clk);
        drive(0, 0, 0, 1, 0, 3'b000, 32'h66, 32'h0, 5'd8);
        @(posedge clk); #1;
        checks++; if (wb_rw !== 1'b0 || wb_alu !== 32'h66) begin failures++;
            $display("FAIL bubble_wb: got rw=%b alu=%h want 0/66", wb_rw, wb_alu); end
    endtask

    task automatic test_sh();
        @(negedge clk);
        drive(1, 0, 1, 0, 0, 3'b001, 32'h106, 32'h0000_BEEF, 5'd0);
        dmif.DM_ready_i = 1;
        #1;
        checks++; if (dmif.DM_web_o !== 4'b1100 || dmif.DM_wdata_o !== 32'hBEEF_BEEF || dmif.DM_addr_o !== 32'h104) begin failures++;
            $display("FAIL sh: got web=%b wdata=%h addr=%h want 1100/beefbeef/104", dmif.DM_web_o, dmif.DM_wdata_o, dmif.DM_addr_o); end
        @(posedge clk);
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        drive(1, 1, 0, 1, 1, 3'b010, 32'h300, 32'h0, 5'd3);
        dmif.DM_ready_i = 1; dmif.DM_rdata_i = 32'h1111_2222;
        @(posedge clk); #1;
        checks++; if (wb_dm !== 32'h1111_2222 || wb_rd !== 5'd3 || wb_alu !== 32'h300) begin failures++;
            $display("FAIL b2b_lw: got dm=%h rd=%0d alu=%h want 11112222/3/300", wb_dm, wb_rd, wb_alu); end
        @(negedge clk);
        drive(1, 0, 1, 0, 0, 3'b010, 32'h304, 32'h0000_0099, 5'd0);
        dmif.DM_ready_i = 0; dmif.DM_rdata_i = 32'h0;
        #1;
        checks++; if (dmif.DM_req_o !== 1'b1 || stall_o !== 1'b1 || dmif.DM_web_o !== 4'b1111 || dmif.DM_wdata_o !== 32'h99) begin failures++;
            $display("FAIL b2b_sw_issue: got req=%b stall=%b web=%b wdata=%h want 1/1/1111/99", dmif.DM_req_o, stall_o, dmif.DM_web_o, dmif.DM_wdata_o); end
        @(negedge clk);
        dmif.DM_ready_i = 1;
        @(posedge clk); #1;
        checks++; if (wb_alu !== 32'h304 || wb_dm !== 32'h0 || wb_rw !== 1'b0) begin failures++;
            $display("FAIL b2b_sw_wb: got alu=%h dm=%h rw=%b want 304/0/0", wb_alu, wb_dm, wb_rw); end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        drive(1, 1, 0, 1, 1, 3'b010, 32'h400, 32'h0, 5'd4);
        dmif.DM_ready_i = 0;
        @(posedge clk);
        #2;
        rstn = 0;
        #1;
        checks++; if (dmif.DM_req_o !== 1'b0 || stall_o !== 1'b0) begin failures++;
            $display("FAIL rstmid_req: got req=%b stall=%b want 0/0", dmif.DM_req_o, stall_o); end
        checks++; if ({wb_lf, wb_dm, wb_alu, wb_rd, wb_rw, wb_m2r} !== '0) begin failures++;
            $display("FAIL rstmid_wb: got alu=%h dm=%h rd=%0d rw=%b want all 0", wb_alu, wb_dm, wb_rd, wb_rw); end
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 3'b000, 32'h0, 32'h0, 5'd0);
        rstn = 1;
        #1;
        checks++; if (dmif.DM_req_o !== 1'b0) begin failures++; $display("FAIL rstmid_idle: got req=%b want 0", dmif.DM_req_o); end
        @(negedge clk);
        drive(1, 1, 0, 1, 1, 3'b010, 32'h404, 32'h0, 5'd4);
        dmif.DM_ready_i = 1; dmif.DM_rdata_i = 32'h77;
        @(posedge clk); #1;
        checks++; if (wb_dm !== 32'h77 || wb_alu !== 32'h404) begin failures++;
            $display("FAIL rstmid_resume: got dm=%h alu=%h want 77/404", wb_dm, wb_alu); end
    endtask

    task automatic test_random();
        logic [2:0]  ldf [5];
        logic [31:0] prev, a, d, rdv, ewd;
        logic [2:0]  f;
        logic [3:0]  ew;
        logic [4:0]  r;
        logic        regw, is_ld, is_mem, v;
        int          kind, delay, hold, sx;
        ldf[0] = 3'b000; ldf[1] = 3'b001; ldf[2] = 3'b010; ldf[3] = 3'b100; ldf[4] = 3'b101;
        prev = 32'h404;
        for (int n = 0; n < 60; n++) begin
            kind   = $urandom_range(0, 3);
            is_ld  = (kind == 0);
            is_mem = (kind < 2);
            v      = (kind != 3);
            a      = $urandom;
            d      = $urandom;
            rdv    = $urandom;
            r      = 5'($urandom_range(0, 31));
            f      = is_ld ? ldf[$urandom_range(0, 4)] : 3'($urandom_range(0, 2));
            regw   = is_ld ? 1'b1 : (kind == 1) ? 1'b0 : 1'($urandom_range(0, 1));
            delay  = $urandom_range(0, 3);
            hold   = $urandom_range(0, 2);
            sx     = $urandom_range(0, 1);
            // reference: word-lane rules as plain arithmetic
            case (f % 4)
                0: begin ew = 4'(32'd1 << (a % 4)); ewd = (d % 256) * 32'h0101_0101; end
                1: begin ew = ((a % 4) >= 2) ? 4'hC : 4'h3; ewd = (d % 65536) * 32'h0001_0001; end
                default: begin ew = 4'hF; ewd = d; end
            endcase
            if (!(kind == 1)) ew = 4'h0;
            if (is_mem) begin
                for (int c = 0; c <= delay; c++) begin
                    @(negedge clk);
                    drive(1, is_ld, !is_ld, regw, is_ld, f, a, d, r);
                    dmif.DM_ready_i = (c == delay);
                    dmif.DM_rdata_i = (c == delay) ? rdv : $urandom;
                    stall_i = (c == delay) && (hold > 0);
                    #1;
                    checks++; if (dmif.DM_req_o !== 1'b1 || stall_o !== (c != delay) || dmif.DM_addr_o !== (a - a % 4) || dmif.DM_web_o !== ew) begin failures++;
                        $display("FAIL rnd_access n=%0d c=%0d: got req=%b stall=%b addr=%h web=%b want 1/%b/%h/%b", n, c, dmif.DM_req_o, stall_o, dmif.DM_addr_o, dmif.DM_web_o, c != delay, a - a % 4, ew); end
                    if (kind == 1) begin
                        checks++; if (dmif.DM_wdata_o !== ewd) begin failures++;
                            $display("FAIL rnd_wdata n=%0d: got %h want %h", n, dmif.DM_wdata_o, ewd); end
                    end
                    checks++; if (wb_alu !== prev) begin failures++; $display("FAIL rnd_wb_held n=%0d: got alu=%h want %h", n, wb_alu, prev); end
                    @(posedge clk);
                end
                for (int h = 1; h <= hold; h++) begin
                    @(negedge clk);
                    dmif.DM_ready_i = 0; dmif.DM_rdata_i = $urandom; stall_i = (h < hold);
                    #1;
                    checks++; if (dmif.DM_req_o !== 1'b0 || stall_o !== 1'b0 || wb_alu !== prev) begin failures++;
                        $display("FAIL rnd_hold n=%0d: got req=%b stall=%b alu=%h want 0/0/%h", n, dmif.DM_req_o, stall_o, wb_alu, prev); end
                    @(posedge clk);
                end
            end else begin
                for (int s = 0; s <= sx; s++) begin
                    @(negedge clk);
                    drive(v, 1'b0, 1'b0, regw, 1'b0, f, a, d, r);
                    dmif.DM_ready_i = 0; stall_i = (s < sx);
                    #1;
                    checks++; if (dmif.DM_req_o !== 1'b0 || stall_o !== 1'b0 || wb_alu !== prev) begin failures++;
                        $display("FAIL rnd_nonmem n=%0d: got req=%b stall=%b alu=%h want 0/0/%h", n, dmif.DM_req_o, stall_o, wb_alu, prev); end
                    @(posedge clk);
                end
            end
            #1;
            checks++;
            if (wb_alu !== a || wb_rd !== r || wb_lf !== f || wb_m2r !== is_ld || wb_rw !== (regw & v) || wb_dm !== (is_ld ? rdv : 32'h0)) begin failures++;
                $display("FAIL rnd_wb n=%0d: got alu=%h rd=%0d lf=%b m2r=%b rw=%b dm=%h want %h/%0d/%b/%b/%b/%h",
                         n, wb_alu, wb_rd, wb_lf, wb_m2r, wb_rw, wb_dm, a, r, f, is_ld, regw & v, is_ld ? rdv : 32'h0); end
            prev = a;
            stall_i = 0;
        end
    endtask

    initial begin
        stall_i = 0;
        dmif.DM_ready_i = 0;
        dmif.DM_rdata_i = 32'h0;
        drive(0, 0, 0, 0, 0, 3'b000, 32'h0, 32'h0, 5'd0);
        test_reset();
        test_sb();
        test_lw_wait();
        test_lh_hold();
        test_alu();
        test_sh();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
